data_mem_alt: RTL and testbench

- Synchronous simple dual-port RAM for the frame-buffer datapath: one write port, one read port, shared clock.
- Read data is registered, with one-cycle latency.
- A per-entry valid bitmap makes every location read as zero after reset until it is written, so the block needs no memory-wide clear loop.

---
 rtl/data_mem_alt.sv | 58 +++++
 tb/tb_data_mem_alt.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_mem_alt.sv
// Simple dual-port RAM with registered read data, one-cycle latency.
// A per-entry valid bitmap makes every location read as zero after reset until it is first written.
module data_mem_alt #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_next;

    // Array is deliberately not reset; the valid bitmap masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    // Write-first on a same-address collision: forward the incoming word.
    always_comb begin
        collide = wr_en && (wr_addr == rd_addr);
        rd_next = '0;
        if (collide) begin
            rd_next = wr_data;
        end else if (valid[rd_addr]) begin
            rd_next = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_data_mem_alt.sv
// Scoreboard bench for data_mem_alt: stimulus pushes the expected rd_data per clocked cycle,
// a monitor pops and compares after every non-reset rising edge.
module tb_data_mem_alt;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [2:0]  rd_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q [$];

    logic [15:0] m_data  [8];
    bit          m_valid [8];
    logic [15:0] m_rd;

    data_mem_alt #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_rd = 16'h0000;
    endtask

    // One clocked cycle with reset released; the reference model follows the plain RAM rules.
    task automatic cycle(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                         input bit re, input logic [2:0] ra);
        @(negedge clk);
        reset   = 1'b0;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re) begin
            if (we && wa == ra) m_rd = wd;
            else if (m_valid[ra]) m_rd = m_data[ra];
            else m_rd = 16'h0000;
        end
        if (we) begin
            m_data[wa]  = wd;
            m_valid[wa] = 1'b1;
        end
        exp_q.push_back(m_rd);
    endtask

    // Reset asserted between edges must clear rd_data before the next edge.
    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b1;
        wr_en = $urandom_range(0, 1);
        rd_en = $urandom_range(0, 1);
        #1;
        tests++;
        if (rd_data !== 16'h0000) begin
            fails++;
            $display("FAIL async_reset: rd_data=%h expected=%h", rd_data, 16'h0000);
        end
        model_clear();
        repeat (hold) @(negedge clk);
    endtask

    initial begin : monitor
        logic [15:0] exp;
        forever begin
            @(posedge clk);
            if (!reset) begin
                #1;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_underflow: rd_data=%h expected=<queued value>", rd_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (rd_data !== exp) begin
                        fails++;
                        $display("FAIL rd_data: got=%h expected=%h", rd_data, exp);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (rd_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: rd_data=%h expected=%h", rd_data, 16'h0000);
        end

        for (int a = 0; a < 8; a++) cycle(0, 3'd0, 16'h0, 1, 3'(a));
        for (int a = 1; a <= 4; a++) cycle(1, 3'(a), 16'(a), 0, 3'd0);
        for (int a = 1; a <= 4; a++) cycle(0, 3'd0, 16'h0, 1, 3'(a));

        cycle(1, 3'd1, 16'h0001, 1, 3'd1);
        cycle(1, 3'd6, 16'h6666, 1, 3'd6);

        cycle(0, 3'd0, 16'h0, 1, 3'd2);
        cycle(0, 3'd0, 16'h0, 0, 3'd3);
        cycle(0, 3'd0, 16'h0, 0, 3'd4);
        cycle(0, 3'd0, 16'h0, 0, 3'd5);

        do_reset(2);
        cycle(0, 3'd0, 16'h0, 1, 3'd2);

        cycle(0, 3'd5, 16'hBEEF, 0, 3'd0);
        cycle(0, 3'd0, 16'h0, 1, 3'd5);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
            cycle($urandom_range(0, 1), 3'($urandom_range(0, 7)), 16'($urandom),
                  $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL sb_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
